galaxian_inputs: RTL and testbench



---
 rtl/galaxian_inputs.sv | 150 +++++++++++++++
 tb/tb_galaxian_inputs.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/galaxian_inputs.sv
// Galaxian-family input conditioning: decodes PS/2 key events into held key
// states, merges them with both joystick words into per-player active-high
// control vectors, and stretches coin requests into fixed-length pulses.
// Every output is registered; the top level inverts and packs them per game.
module galaxian_inputs #(
    parameter int unsigned COIN_PULSE = 600000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        ioctl_download,
    output logic [4:0]  p1_ctrl,
    output logic [4:0]  p2_ctrl,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin2,
    output logic        test
);

    // Pulse counter reload value; the pulse lasts from the load edge until
    // the edge on which the counter is found at zero.
    localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE - 1);

    // Reset and download both flush every piece of state except old_tog.
    logic clear;
    assign clear = reset | ioctl_download;

    // Key word fields.
    logic       key_tog;
    logic       key_pressed;
    logic       key_ext;
    logic [7:0] key_code;
    assign key_tog     = ps2_key[10];
    assign key_pressed = ps2_key[9];
    assign key_ext     = ps2_key[8];
    assign key_code    = ps2_key[7:0];

    // Joystick bits above the coin bit carry nothing for these games.
    logic unused_joy;
    assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8]};

    // Event detection: a new key event is signalled by a toggle of bit 10.
    logic old_tog;
    logic key_event;
    assign key_event = key_tog != old_tog;

    // Held key states.
    logic up1, down1, left1, right1, fire1;
    logic up2, down2, left2, right2, fire2;
    logic st1, st2, kc1, kc2, test_key;

    // Coin stretcher state, index 0 = coin1, index 1 = coin2.
    logic [1:0]  req;
    logic [1:0]  req_prev;
    logic [1:0]  active;
    logic [23:0] cnt [2];

    assign req = {kc2 | joystick_1[7], kc1 | joystick_0[7]};

    // Toggle tracker reloads unconditionally so events raised during reset
    // or download are swallowed rather than replayed afterwards.
    always_ff @(posedge clk_sys) begin
        old_tog <= key_tog;
    end

    // Key decode: arrows accept either extended flag, all others need ext=0.
    always_ff @(posedge clk_sys) begin
        if (clear) begin
            {up1, down1, left1, right1, fire1} <= '0;
            {up2, down2, left2, right2, fire2} <= '0;
            {st1, st2, kc1, kc2, test_key}     <= '0;
        end else if (key_event) begin
            case (key_code)
                8'h75: up1    <= key_pressed;
                8'h72: down1  <= key_pressed;
                8'h6B: left1  <= key_pressed;
                8'h74: right1 <= key_pressed;
                default: begin
                    if (!key_ext) begin
                        case (key_code)
                            8'h29, 8'h14: fire1    <= key_pressed;
                            8'h05, 8'h16: st1      <= key_pressed;
                            8'h06, 8'h1E: st2      <= key_pressed;
                            8'h2E:        kc1      <= key_pressed;
                            8'h36:        kc2      <= key_pressed;
                            8'h2D:        up2      <= key_pressed;
                            8'h2B:        down2    <= key_pressed;
                            8'h23:        left2    <= key_pressed;
                            8'h34:        right2   <= key_pressed;
                            8'h1C:        fire2    <= key_pressed;
                            8'h2C:        test_key <= key_pressed;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Coin stretchers: one pulse per request rising edge, no queueing.
    // req_prev is held high while cleared so a request still held on exit
    // does not count as a fresh edge.
    always_ff @(posedge clk_sys) begin
        if (clear) begin
            req_prev <= 2'b11;
            active   <= 2'b00;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                req_prev[i] <= req[i];
                if (active[i]) begin
                    if (cnt[i] == 24'd0) begin
                        active[i] <= 1'b0;
                    end else begin
                        cnt[i] <= cnt[i] - 24'd1;
                    end
                end else if (req[i] && !req_prev[i]) begin
                    active[i] <= 1'b1;
                    cnt[i]    <= PULSE_LOAD;
                end
            end
        end
    end

    // Output merge register: key latches OR joystick bits, already in
    // {fire, up, down, left, right} order on the joystick side.
    always_ff @(posedge clk_sys) begin
        if (clear) begin
            p1_ctrl <= '0;
            p2_ctrl <= '0;
            start1  <= 1'b0;
            start2  <= 1'b0;
            test    <= 1'b0;
        end else begin
            p1_ctrl <= {fire1, up1, down1, left1, right1} | joystick_0[4:0];
            p2_ctrl <= {fire2, up2, down2, left2, right2} | joystick_1[4:0];
            start1  <= st1 | joystick_0[5] | joystick_1[5];
            start2  <= st2 | joystick_0[6] | joystick_1[6];
            test    <= test_key;
        end
    end

    assign coin1 = active[0];
    assign coin2 = active[1];

endmodule

// File: tb/tb_galaxian_inputs.sv
// Directed bench for galaxian_inputs with a short coin pulse.
module tb_galaxian_inputs;

    localparam int PULSE = 8;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic        ioctl_download = 1'b0;
    logic [4:0]  p1_ctrl;
    logic [4:0]  p2_ctrl;
    logic        start1;
    logic        start2;
    logic        coin1;
    logic        coin2;
    logic        test;

    int   checks = 0;
    int   errors = 0;
    logic tog = 1'b0;

    galaxian_inputs #(.COIN_PULSE(PULSE)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ps2_key        (ps2_key),
        .joystick_0     (joystick_0),
        .joystick_1     (joystick_1),
        .ioctl_download (ioctl_download),
        .p1_ctrl        (p1_ctrl),
        .p2_ctrl        (p2_ctrl),
        .start1         (start1),
        .start2         (start2),
        .coin1          (coin1),
        .coin2          (coin2),
        .test           (test)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        tog = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic test_reset();
        logic [14:0] all_out;
        reset = 1'b1;
        joystick_0 = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            tick();
            all_out = {p1_ctrl, p2_ctrl, start1, start2, coin1, coin2, test};
            checks++;
            if (all_out !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, all_out);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (p1_ctrl !== 5'h1F) begin
            errors++;
            $display("FAIL reset_release_p1: got %h expected 1f", p1_ctrl);
        end
        checks++;
        if ({start1, start2} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_start: got %b expected 11", {start1, start2});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (coin1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_held_coin cycle %0d: got %b expected 0", i, coin1);
            end
            tick();
        end
        joystick_0 = 16'h0000;
        tick();
        checks++;
        if ({p1_ctrl, start1, start2} !== 7'd0) begin
            errors++;
            $display("FAIL reset_joy_drop: got %h expected 0", {p1_ctrl, start1, start2});
        end
    endtask

    task automatic test_keyboard();
        // extended up press: latch on first edge, output on second
        send_key(1'b1, 1'b1, 8'h75);
        tick();
        checks++;
        if (p1_ctrl !== 5'h00) begin
            errors++;
            $display("FAIL key_latency_early: got %h expected 00", p1_ctrl);
        end
        tick();
        checks++;
        if (p1_ctrl !== 5'h08) begin
            errors++;
            $display("FAIL key_up_press: got %h expected 08", p1_ctrl);
        end
        send_key(1'b0, 1'b0, 8'h75);
        tick(); tick();
        checks++;
        if (p1_ctrl !== 5'h00) begin
            errors++;
            $display("FAIL key_up_release: got %h expected 00", p1_ctrl);
        end
        // unknown code and extended non-arrow must both be ignored
        send_key(1'b1, 1'b0, 8'h09);
        tick(); tick();
        send_key(1'b1, 1'b1, 8'h29);
        tick(); tick();
        checks++;
        if ({p1_ctrl, p2_ctrl, start1, start2, test} !== 13'd0) begin
            errors++;
            $display("FAIL key_ignored: got %h expected 0", {p1_ctrl, p2_ctrl, start1, start2, test});
        end
        // shared fire latch: press on 0x29, release on 0x14
        send_key(1'b1, 1'b0, 8'h29);
        tick(); tick();
        checks++;
        if (p1_ctrl !== 5'h10) begin
            errors++;
            $display("FAIL key_fire_press: got %h expected 10", p1_ctrl);
        end
        send_key(1'b0, 1'b0, 8'h14);
        tick(); tick();
        checks++;
        if (p1_ctrl !== 5'h00) begin
            errors++;
            $display("FAIL key_fire_shared_release: got %h expected 00", p1_ctrl);
        end
        send_key(1'b1, 1'b0, 8'h2C);
        tick(); tick();
        checks++;
        if (test !== 1'b1) begin
            errors++;
            $display("FAIL key_test_press: got %b expected 1", test);
        end
        send_key(1'b0, 1'b0, 8'h2C);
        tick(); tick();
    endtask

    task automatic test_coin_pulse();
        int   highs;
        int   rises;
        logic prev;
        for (int pass = 0; pass < 2; pass++) begin
            joystick_0 = 16'h0080;
            highs = 0; rises = 0; prev = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (i == 0) begin
                    checks++;
                    if (coin1 !== 1'b1) begin
                        errors++;
                        $display("FAIL coin_joy_latency pass %0d: got %b expected 1", pass, coin1);
                    end
                end
                if (coin1 === 1'b1) highs++;
                if (coin1 === 1'b1 && prev === 1'b0) rises++;
                prev = coin1;
            end
            checks++;
            if (highs !== PULSE) begin
                errors++;
                $display("FAIL coin_pulse_len pass %0d: got %0d expected %0d", pass, highs, PULSE);
            end
            checks++;
            if (rises !== 1) begin
                errors++;
                $display("FAIL coin_pulse_count pass %0d: got %0d expected 1", pass, rises);
            end
            joystick_0 = 16'h0000;
            tick(); tick();
        end
    endtask

    task automatic test_retrigger();
        int   highs;
        int   rises;
        int   c2_highs;
        logic prev;
        highs = 0; rises = 0; c2_highs = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) send_key((i % 2) == 0, 1'b0, 8'h2E);
            tick();
            if (coin1 === 1'b1) highs++;
            if (coin1 === 1'b1 && prev === 1'b0) rises++;
            if (coin2 !== 1'b0) c2_highs++;
            prev = coin1;
        end
        checks++;
        if (highs !== PULSE) begin
            errors++;
            $display("FAIL retrigger_len: got %0d expected %0d", highs, PULSE);
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL retrigger_count: got %0d expected 1", rises);
        end
        checks++;
        if (c2_highs !== 0) begin
            errors++;
            $display("FAIL retrigger_coin2: got %0d high cycles expected 0", c2_highs);
        end
    endtask

    task automatic test_key_coin_latency();
        int highs;
        send_key(1'b1, 1'b0, 8'h36);
        tick();
        checks++;
        if (coin2 !== 1'b0) begin
            errors++;
            $display("FAIL key_coin_early: got %b expected 0", coin2);
        end
        tick();
        checks++;
        if (coin2 !== 1'b1) begin
            errors++;
            $display("FAIL key_coin_latency: got %b expected 1", coin2);
        end
        highs = 1;
        send_key(1'b0, 1'b0, 8'h36);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (coin2 === 1'b1) highs++;
        end
        checks++;
        if (highs !== PULSE) begin
            errors++;
            $display("FAIL key_coin_len: got %0d expected %0d", highs, PULSE);
        end
    endtask

    task automatic test_download();
        send_key(1'b1, 1'b0, 8'h29);
        tick(); tick();
        checks++;
        if (p1_ctrl !== 5'h10) begin
            errors++;
            $display("FAIL dl_fire_before: got %h expected 10", p1_ctrl);
        end
        ioctl_download = 1'b1;
        send_key(1'b1, 1'b1, 8'h75);
        tick();
        checks++;
        if (p1_ctrl !== 5'h00) begin
            errors++;
            $display("FAIL dl_forced_zero: got %h expected 00", p1_ctrl);
        end
        joystick_0 = 16'h0080;
        tick(); tick();
        checks++;
        if (coin1 !== 1'b0) begin
            errors++;
            $display("FAIL dl_coin_forced: got %b expected 0", coin1);
        end
        ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({p1_ctrl, coin1} !== 6'd0) begin
                errors++;
                $display("FAIL dl_after cycle %0d: p1_ctrl=%h coin1=%b expected 00/0", i, p1_ctrl, coin1);
            end
        end
        joystick_0 = 16'h0000;
        tick();
    endtask

    task automatic test_reset_mid_pulse();
        joystick_0 = 16'h0080;
        tick();
        checks++;
        if (coin1 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_start: got %b expected 1", coin1);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (coin1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got %b expected 0", coin1);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (coin1 !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_retrigger cycle %0d: got %b expected 0", i, coin1);
            end
        end
        joystick_0 = 16'h0000;
        tick();
    endtask

    task automatic test_player2();
        send_key(1'b1, 1'b0, 8'h2D);
        joystick_1 = 16'h0010;
        tick();
        checks++;
        if (p2_ctrl !== 5'h10) begin
            errors++;
            $display("FAIL p2_joy_latency: got %h expected 10", p2_ctrl);
        end
        tick();
        checks++;
        if (p2_ctrl !== 5'h18) begin
            errors++;
            $display("FAIL p2_merge: got %h expected 18", p2_ctrl);
        end
        checks++;
        if (p1_ctrl !== 5'h00) begin
            errors++;
            $display("FAIL p2_p1_isolated: got %h expected 00", p1_ctrl);
        end
        joystick_1 = 16'h0030;
        tick();
        checks++;
        if ({start1, start2} !== 2'b10) begin
            errors++;
            $display("FAIL p2_start1: got %b expected 10", {start1, start2});
        end
        // key release with joystick still holding fire keeps fire high
        send_key(1'b0, 1'b0, 8'h2D);
        tick(); tick();
        checks++;
        if (p2_ctrl !== 5'h10) begin
            errors++;
            $display("FAIL p2_release_held: got %h expected 10", p2_ctrl);
        end
        joystick_1 = 16'h0000;
        send_key(1'b1, 1'b0, 8'h1E);
        tick(); tick();
        checks++;
        if ({start1, start2, p2_ctrl} !== 7'b01_00000) begin
            errors++;
            $display("FAIL p2_key_start2: got %b expected 0100000", {start1, start2, p2_ctrl});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_keyboard();
        test_coin_pulse();
        test_retrigger();
        test_key_coin_latency();
        test_download();
        test_reset_mid_pulse();
        test_player2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
